alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, registered ALU for the ITSC-16 datapath with valid/ready handshake and an internal flag register.
//  Same opcode map as the 16-bit combinational ALU; MUL/DIV/MOD run iteratively over WIDTH cycles, all other ops in one.
//  Sits between register-file read and writeback; the flag register feeds branch logic directly.
// PARAMETERS
//  WIDTH   16  operand/result width (>=4)
//  FUNC_W  5   opcode width
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        operands/opcode valid
//  in_ready   out  1        ALU can accept (high only in IDLE)
//  a, b       in   WIDTH    operands (b = shift amount for shift ops)
//  func       in   FUNC_W   opcode
//  flags_we   in   1        load flag register from flags_in (honoured in IDLE only)
//  flags_in   in   6        flag restore value
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer takes result
//  y          out  WIDTH    result
//  flags      out  6        flag register {Z,V,C,P,G,L} = bits [5:0]
// BEHAVIOUR
//  Reset: state IDLE; y=0, flags=0, out_valid=0, in_ready=1. Reset mid-op aborts it; no partial result or flags.
//  FSM: IDLE -(accept, MUL/DIV/MOD with b!=0)-> BUSY; IDLE -(accept, other)-> DONE; BUSY -(WIDTH cycles)-> DONE;
//       DONE -(out_ready)-> IDLE. Accept = in_valid & in_ready; operands/func latched on accept.
//  Latency: out_valid 1 cycle after accept for 1-cycle ops, WIDTH+1 cycles for MUL/DIV/MOD (b!=0).
//  DONE: y and flags stable while out_ready=0; no new accept until back in IDLE (no overlap).
//  Flags written at the DONE transition. flags_we in IDLE loads flags_in; if it coincides with an accept,
//    the op uses flags_in[3] as carry-in.
//  Opcodes (0..17): ADD,SUB,MUL,DIV,MOD,MVN,OR,AND,ORN,ANDN,EOR,EON,REV,LSL,LSR,ASR,NOP,CMP.
//  ADD: {C,y}=a+b+C. SUB: y=a-b-C, C=borrow. V=signed overflow (2's complement).
//  MUL: y=low WIDTH of a*b (unsigned), V=(high half!=0), C=0. Iterative shift-add, 1 bit/cycle.
//  DIV/MOD: unsigned restoring division, 1 quotient bit/cycle; y=quotient / remainder, V=0, C=0.
//    b==0: 1-cycle op; DIV y=all ones, MOD y=a, V=1.
//  MVN y=~b; ORN y=~(a|b); ANDN y=~(a&b); EOR y=a^b; EON y=~(a^b); REV swaps the two WIDTH/2 halves of b.
//  Shifts, amount n=b: n==0 -> y=a, C=0; 1..WIDTH-1 -> C=last bit shifted out;
//    n>=WIDTH -> LSL/LSR y=0, ASR y=all copies of a[WIDTH-1], C=0. ASR is signed.
//  Logic/REV/MVN: C=0, V=0.
//  All result ops: Z=(y==0), P=~^y (even parity), G=L=0.
//  CMP: y=0; Z=(a==b), G=(a>b), L=(a<b) unsigned; C=V=P=0. NOP: y=0, flags unchanged.
//  Opcodes 18..2^FUNC_W-1: 1-cycle, y=0, flags cleared.
// STRUCTURE
//  Package alu_pkg: op_e enum (values 0..17), flag index localparams (FLAG_Z=5..FLAG_L=0), state_e {IDLE,BUSY,DONE}.
//  Sub-module alu_muldiv_iter: start/done iterative multiplier/divider with its WIDTH-cycle counter.
//    Top holds the FSM, 1-cycle ops and flag register.
// TESTING (WIDTH=16)
//  1 ADD a=10000 b=2 C=0 -> y=10002, Z=0 C=0, out_valid 1 cycle after accept.
//  2 ADD 0xFFFF+0x0001 -> y=0 Z=1 C=1; then ADD 0+0 -> y=1 (carry chained).
//    flags_we with 0x08 plus same-cycle ADD 0+0 -> y=1.
//  3 MUL 0x0100*0x0100 -> y=0 V=1 Z=1, out_valid 17 cycles after accept, in_ready=0 throughout.
//  4 DIV 0x00F6/0x000A -> y=0x0018; MOD -> y=0x0006; DIV 0x1234/0 -> y=0xFFFF V=1 in 1 cycle.
//  5 ASR 0x8000 by 4 -> 0xF800 C=0; LSL 0x8001 by 1 -> 0x0002 C=1; LSR by 20 -> 0;
//    CMP 5,7 -> L=1 G=0 Z=0 y=0.
//  6 out_ready low 5 cycles -> y/flags stable, in_ready=0.
//    rst during DIV BUSY -> next cycle out_valid=0 in_ready=1 flags=0.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Opcode map, flag bit positions and FSM states for alu_seq.
//  Revision : 1.0
// ============================================================================
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_MUL  = 5'd2,
        OP_DIV  = 5'd3,
        OP_MOD  = 5'd4,
        OP_MVN  = 5'd5,
        OP_OR   = 5'd6,
        OP_AND  = 5'd7,
        OP_ORN  = 5'd8,
        OP_ANDN = 5'd9,
        OP_EOR  = 5'd10,
        OP_EON  = 5'd11,
        OP_REV  = 5'd12,
        OP_LSL  = 5'd13,
        OP_LSR  = 5'd14,
        OP_ASR  = 5'd15,
        OP_NOP  = 5'd16,
        OP_CMP  = 5'd17
    } op_e;

    localparam int FLAG_Z = 5;
    localparam int FLAG_V = 4;
    localparam int FLAG_C = 3;
    localparam int FLAG_P = 2;
    localparam int FLAG_G = 1;
    localparam int FLAG_L = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_muldiv_iter
//  Purpose  : Iterative unsigned shift-add multiplier / restoring divider,
//             one bit per cycle, WIDTH cycles from start to done.
//  Revision : 1.0
// ============================================================================
module alu_muldiv_iter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    logic             r_busy;
    logic             r_div;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_d;

    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sh;
    logic             w_geq;
    logic [WIDTH-1:0] w_sub;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;

    // MUL: {hi,lo} holds partial product over the multiplier in lo.
    // DIV: hi is the running remainder, lo shifts dividend out and quotient in.
    assign w_add = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_d} : {(WIDTH+1){1'b0}});
    assign w_sh  = {r_hi, r_lo[WIDTH-1]};
    assign w_geq = (w_sh >= {1'b0, r_d});
    // The difference is always below the divisor, so the low WIDTH bits are exact.
    assign w_sub = w_sh[WIDTH-1:0] - r_d;

    assign w_hi_nxt = r_div ? (w_geq ? w_sub : w_sh[WIDTH-1:0]) : w_add[WIDTH:1];
    assign w_lo_nxt = r_div ? {r_lo[WIDTH-2:0], w_geq} : {w_add[0], r_lo[WIDTH-1:1]};

    assign done   = r_busy && (r_cnt == c_last);
    assign res_hi = w_hi_nxt;
    assign res_lo = w_lo_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_div  <= 1'b0;
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_d    <= '0;
        end else if (start) begin
            r_busy <= 1'b1;
            r_div  <= div;
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= div ? a : b;
            r_d    <= div ? b : a;
        end else if (r_busy) begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Purpose  : Registered ITSC-16 ALU with valid/ready handshake, flag
//             register and iterative MUL/DIV/MOD.
//  Revision : 1.0
// ============================================================================
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int FUNC_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [FUNC_W-1:0] func,
    input  logic              flags_we,
    input  logic [5:0]        flags_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  y,
    output logic [5:0]        flags
);

    localparam int c_half = WIDTH / 2;

    state_e            r_state;
    logic [FUNC_W-1:0] r_func;
    logic [WIDTH-1:0]  r_y;
    logic [5:0]        r_flags;
    logic              r_out_valid;
    logic              r_in_ready;

    logic              w_accept;
    logic              w_iter;
    logic [5:0]        w_flags_base;
    logic              w_cin;
    logic              w_big;
    logic [WIDTH:0]    w_shl;
    logic [WIDTH:0]    w_shr;
    logic [WIDTH:0]    w_sar;
    logic [WIDTH-1:0]  w_y1;
    logic [5:0]        w_f1;
    logic              w_c;
    logic              w_v;
    logic              w_res;

    logic              w_md_done;
    logic [WIDTH-1:0]  w_md_hi;
    logic [WIDTH-1:0]  w_md_lo;
    logic [WIDTH-1:0]  w_md_y;
    logic [5:0]        w_md_f;

    assign w_accept = in_valid & r_in_ready;
    assign w_iter   = ((func == FUNC_W'(OP_MUL)) || (func == FUNC_W'(OP_DIV)) ||
                       (func == FUNC_W'(OP_MOD))) && (b != '0);

    // A same-cycle flag restore supplies the carry-in of the accepted op.
    assign w_flags_base = flags_we ? flags_in : r_flags;
    assign w_cin        = w_flags_base[FLAG_C];

    assign w_big = (b >= WIDTH'(WIDTH));
    assign w_shl = {1'b0, a} << b;
    assign w_shr = {a, 1'b0} >> b;
    assign w_sar = $signed({a, 1'b0}) >>> b;

    always_comb begin
        w_y1  = '0;
        w_f1  = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_res = 1'b1;
        case (func)
            FUNC_W'(OP_ADD): begin
                {w_c, w_y1} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, w_cin};
                w_v = (a[WIDTH-1] == b[WIDTH-1]) && (w_y1[WIDTH-1] != a[WIDTH-1]);
            end
            FUNC_W'(OP_SUB): begin
                {w_c, w_y1} = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, w_cin};
                w_v = (a[WIDTH-1] != b[WIDTH-1]) && (w_y1[WIDTH-1] != a[WIDTH-1]);
            end
            // MUL/DIV/MOD only take this path when b is zero.
            FUNC_W'(OP_MUL):  w_y1 = '0;
            FUNC_W'(OP_DIV): begin
                w_y1 = '1;
                w_v  = 1'b1;
            end
            FUNC_W'(OP_MOD): begin
                w_y1 = a;
                w_v  = 1'b1;
            end
            FUNC_W'(OP_MVN):  w_y1 = ~b;
            FUNC_W'(OP_OR):   w_y1 = a | b;
            FUNC_W'(OP_AND):  w_y1 = a & b;
            FUNC_W'(OP_ORN):  w_y1 = ~(a | b);
            FUNC_W'(OP_ANDN): w_y1 = ~(a & b);
            FUNC_W'(OP_EOR):  w_y1 = a ^ b;
            FUNC_W'(OP_EON):  w_y1 = ~(a ^ b);
            FUNC_W'(OP_REV):  w_y1 = {b[c_half-1:0], b[WIDTH-1:c_half]};
            FUNC_W'(OP_LSL): begin
                if (b == '0)  w_y1 = a;
                else if (!w_big) {w_c, w_y1} = w_shl;
            end
            FUNC_W'(OP_LSR): begin
                if (b == '0)  w_y1 = a;
                else if (!w_big) {w_y1, w_c} = w_shr;
            end
            FUNC_W'(OP_ASR): begin
                if (b == '0)  w_y1 = a;
                else if (w_big) w_y1 = {WIDTH{a[WIDTH-1]}};
                else          {w_y1, w_c} = w_sar;
            end
            FUNC_W'(OP_NOP): begin
                w_res = 1'b0;
                w_f1  = w_flags_base;
            end
            FUNC_W'(OP_CMP): begin
                w_res        = 1'b0;
                w_f1[FLAG_Z] = (a == b);
                w_f1[FLAG_G] = (a > b);
                w_f1[FLAG_L] = (a < b);
            end
            default: w_res = 1'b0;
        endcase
        if (w_res) begin
            w_f1[FLAG_Z] = ~|w_y1;
            w_f1[FLAG_V] = w_v;
            w_f1[FLAG_C] = w_c;
            w_f1[FLAG_P] = ~^w_y1;
        end
    end

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (w_accept & w_iter),
        .div    (func != FUNC_W'(OP_MUL)),
        .a      (a),
        .b      (b),
        .done   (w_md_done),
        .res_hi (w_md_hi),
        .res_lo (w_md_lo)
    );

    always_comb begin
        w_md_y = w_md_lo;
        w_md_f = '0;
        if (r_func == FUNC_W'(OP_MOD)) begin
            w_md_y = w_md_hi;
        end
        if (r_func == FUNC_W'(OP_MUL)) begin
            w_md_f[FLAG_V] = |w_md_hi;
        end
        w_md_f[FLAG_Z] = ~|w_md_y;
        w_md_f[FLAG_P] = ~^w_md_y;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_func      <= '0;
            r_y         <= '0;
            r_flags     <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (flags_we) begin
                        r_flags <= flags_in;
                    end
                    if (w_accept) begin
                        r_func     <= func;
                        r_in_ready <= 1'b0;
                        if (w_iter) begin
                            r_state <= BUSY;
                        end else begin
                            r_state     <= DONE;
                            r_y         <= w_y1;
                            r_flags     <= w_f1;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (w_md_done) begin
                        r_state     <= DONE;
                        r_y         <= w_md_y;
                        r_flags     <= w_md_f;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign flags     = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq
//  Purpose  : Scoreboard bench for alu_seq (WIDTH=16) with directed vectors.
//  Revision : 1.0
// ============================================================================
module tb_alu_seq;

    localparam logic [4:0] c_add = 5'd0,  c_sub = 5'd1,  c_mul = 5'd2,  c_div = 5'd3;
    localparam logic [4:0] c_mod = 5'd4,  c_eor = 5'd10, c_rev = 5'd12, c_lsl = 5'd13;
    localparam logic [4:0] c_lsr = 5'd14, c_asr = 5'd15, c_nop = 5'd16, c_cmp = 5'd17;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [4:0]  func;
    logic        flags_we;
    logic [5:0]  flags_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] y;
    logic [5:0]  flags;

    typedef struct {
        logic [15:0] y;
        logic [5:0]  f;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    alu_seq #(
        .WIDTH  (16),
        .FUNC_W (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .func      (func),
        .flags_we  (flags_we),
        .flags_in  (flags_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Monitor: pops the expected result on every output handshake.
    initial begin
        automatic exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=%0h required=none", y);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.nm, "_y"}, 32'(y), 32'(e.y));
                    chk({e.nm, "_flags"}, 32'(flags), 32'(e.f));
                end
            end
        end
    end

    task automatic do_op(input logic [4:0] f, input logic [15:0] av, input logic [15:0] bv,
                         input logic fwe, input logic [5:0] fin,
                         input logic [15:0] ey, input logic [5:0] ef,
                         input int lat, input int stall, input string nm);
        int   n;
        logic saw_ready;
        @(posedge clk); #1;
        chk({nm, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        func      = f;
        a         = av;
        b         = bv;
        flags_we  = fwe;
        flags_in  = fin;
        out_ready = (stall == 0);
        exp_q.push_back('{ey, ef, nm});
        @(posedge clk); #1;
        in_valid  = 1'b0;
        flags_we  = 1'b0;
        a         = '0;
        b         = '0;
        n         = 1;
        saw_ready = 1'b0;
        while (!out_valid && n < 100) begin
            saw_ready |= in_ready;
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_latency"}, 32'(n), 32'(lat));
        saw_ready |= in_ready;
        chk({nm, "_in_ready_busy"}, 32'(saw_ready), 32'd0);
        for (int i = 0; i < stall; i++) begin
            chk({nm, "_stall_y"}, 32'(y), 32'(ey));
            chk({nm, "_stall_flags"}, 32'(flags), 32'(ef));
            chk({nm, "_stall_valid"}, 32'(out_valid), 32'd1);
            chk({nm, "_stall_in_ready"}, 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        func      = '0;
        flags_we  = 1'b0;
        flags_in  = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_y", 32'(y), 32'd0);
        chk("reset_flags", 32'(flags), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        //     op     a        b        fwe  fin     exp y    exp {Z,V,C,P,G,L} lat stall
        do_op(c_add, 16'd10000, 16'd2,  0, 6'h00, 16'd10002, 6'b000100, 1,  0, "add_basic");
        do_op(c_add, 16'hFFFF, 16'h0001, 0, 6'h00, 16'h0000, 6'b101100, 1,  0, "add_carry_out");
        do_op(c_add, 16'h0000, 16'h0000, 0, 6'h00, 16'h0001, 6'b000000, 1,  0, "add_carry_chain");
        do_op(c_add, 16'h0000, 16'h0000, 1, 6'h08, 16'h0001, 6'b000000, 1,  0, "add_flags_we_cin");
        do_op(c_mul, 16'h0100, 16'h0100, 0, 6'h00, 16'h0000, 6'b110100, 17, 0, "mul_overflow");
        do_op(c_div, 16'h00F6, 16'h000A, 0, 6'h00, 16'h0018, 6'b000100, 17, 0, "div");
        do_op(c_mod, 16'h00F6, 16'h000A, 0, 6'h00, 16'h0006, 6'b000100, 17, 0, "mod");
        do_op(c_div, 16'h1234, 16'h0000, 0, 6'h00, 16'hFFFF, 6'b010100, 1,  0, "div_by_zero");
        do_op(c_asr, 16'h8000, 16'd4,    0, 6'h00, 16'hF800, 6'b000000, 1,  0, "asr");
        do_op(c_lsl, 16'h8001, 16'd1,    0, 6'h00, 16'h0002, 6'b001000, 1,  0, "lsl");
        do_op(c_nop, 16'h1111, 16'h2222, 0, 6'h00, 16'h0000, 6'b001000, 1,  0, "nop");
        do_op(5'd20, 16'h1111, 16'h2222, 0, 6'h00, 16'h0000, 6'b000000, 1,  0, "undef_op");
        do_op(c_lsr, 16'h8001, 16'd20,   0, 6'h00, 16'h0000, 6'b100100, 1,  0, "lsr_big");
        do_op(c_cmp, 16'd5,    16'd7,    0, 6'h00, 16'h0000, 6'b000001, 1,  0, "cmp_less");
        do_op(c_sub, 16'd5,    16'd7,    0, 6'h00, 16'hFFFE, 6'b001000, 1,  0, "sub_borrow");
        do_op(c_sub, 16'd10,   16'd3,    0, 6'h00, 16'h0006, 6'b000100, 1,  0, "sub_borrow_in");
        do_op(c_eor, 16'hF0F0, 16'hFF00, 0, 6'h00, 16'h0FF0, 6'b000100, 1,  0, "eor");
        do_op(c_rev, 16'h0000, 16'h1234, 0, 6'h00, 16'h3412, 6'b000000, 1,  0, "rev");
        do_op(c_add, 16'h7FFF, 16'h0001, 0, 6'h00, 16'h8000, 6'b010000, 1,  5, "add_ovf_stall");

        // Reset while a division is iterating must discard it entirely.
        @(posedge clk); #1;
        in_valid = 1'b1;
        func     = c_div;
        a        = 16'h1234;
        b        = 16'h0007;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("div_busy_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
        chk("rst_mid_flags", 32'(flags), 32'd0);
        chk("rst_mid_y", 32'(y), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("rst_mid_no_late_result", 32'(out_valid), 32'd0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
